// File: rtl/adder_pkg.sv
// Shared configuration for the pipelined adder: default geometry, chunk width
// derivation and the geometry legality check used at elaboration.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  localparam int DEFAULT_CHUNK = chunk_w(DEFAULT_WIDTH, DEFAULT_STAGES);

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the carry
// into the chunk's top bit so the final stage can form signed overflow.
module adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic carry;

  always_comb begin
    s     = '0;
    cmsb  = 1'b0;
    carry = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cmsb = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder, one CHUNK-bit slice per stage, valid/ready flow.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int CUR_W  = WIDTH - k * CHUNK;
    localparam int DONE_W = (k + 1) * CHUNK;

    logic [CUR_W-1:0]  a_cur;
    logic [CUR_W-1:0]  b_cur;
    logic              c_in;
    logic              vld_in;
    logic              rdy;
    logic              load;
    logic [CHUNK-1:0]  s_ch;
    logic              c_out;
    logic              cmsb;
    logic              unused_cmsb;
    logic [DONE_W-1:0] sum_d;
    logic [DONE_W-1:0] sum_q;
    logic              vld_q;
    logic              c_q;

    // Stage k input: the ports for stage 0, register k-1 otherwise
    if (k == 0) begin : g_src
      assign a_cur  = a;
      assign b_cur  = b;
      assign c_in   = cin;
      assign vld_in = in_valid;
      assign sum_d  = s_ch;
    end else begin : g_src
      assign a_cur  = g_stg[k-1].g_fwd.a_q;
      assign b_cur  = g_stg[k-1].g_fwd.b_q;
      assign c_in   = g_stg[k-1].c_q;
      assign vld_in = g_stg[k-1].vld_q;
      assign sum_d  = {s_ch, g_stg[k-1].sum_q};
    end

    if (k == STAGES - 1) begin : g_rdy
      assign rdy = out_ready;
    end else begin : g_rdy
      assign rdy = !g_stg[k+1].vld_q || g_stg[k+1].rdy;
    end

    assign load = !vld_q || rdy;

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_cur[CHUNK-1:0]),
      .b    (b_cur[CHUNK-1:0]),
      .cin  (c_in),
      .s    (s_ch),
      .cout (c_out),
      .cmsb (cmsb)
    );

    // Only the last stage's MSB carry matters, and only for overflow
    assign unused_cmsb = cmsb;

    // Stage k register: data only moves with a valid beat so a stalled or idle
    // output never changes under the consumer
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (load) begin
        vld_q <= vld_in;
        if (vld_in) begin
          sum_q <= sum_d;
          c_q   <= c_out;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int REM_W = CUR_W - CHUNK;
      logic [REM_W-1:0] a_q;
      logic [REM_W-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load && vld_in) begin
          a_q <= a_cur[CUR_W-1:CHUNK];
          b_q <= b_cur[CUR_W-1:CHUNK];
        end
      end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_d;
      logic ovf_q;
      assign ovf_d = cmsb ^ c_out;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (load && vld_in) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign in_ready  = g_stg[0].load;
  assign out_valid = g_stg[STAGES-1].vld_q;
  assign sum       = g_stg[STAGES-1].sum_q;
  assign cout      = g_stg[STAGES-1].c_q;
`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf       = g_stg[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder in three geometries: 8/2, 16/4 and 8/1.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic        iv8, ir8, ov8, or8, cin8, co8;
  logic [7:0]  a8, b8, s8;
  logic        iv16, ir16, ov16, or16, cin16, co16;
  logic [15:0] a16, b16, s16;
  logic        iv1, ir1, ov1, or1, cin1, co1;
  logic [7:0]  a1, b1, s1;
`ifdef PIPELINED_ADDER_OVF_EN
  logic        ovf8, ovf16, ovf1;
`endif

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8),
`ifdef PIPELINED_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .cout(co8)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16),
`ifdef PIPELINED_ADDER_OVF_EN
    .ovf(ovf16),
`endif
    .cout(co16)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(s1),
`ifdef PIPELINED_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .cout(co1)
  );

  task automatic test_reset();
    #2;
    checks++; if (ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0) begin
      errors++; $display("FAIL reset8: valid/sum/cout=%b/%h/%b want 0/00/0", ov8, s8, co8); end
    checks++; if (ov16 !== 1'b0 || s16 !== 16'h0000 || ov1 !== 1'b0 || s1 !== 8'h00) begin
      errors++; $display("FAIL reset_other: v16=%b s16=%h v1=%b s1=%h want zeros", ov16, s16, ov1, s1); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if ({ir8, ir16, ir1} !== 3'b111) begin
      errors++; $display("FAIL reset_in_ready: got %b want 111", {ir8, ir16, ir1}); end
    @(posedge clk); #1;
  endtask

  task automatic run_op8(input string name, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic [7:0] es, input logic ec, input logic eo);
    a8 = ta; b8 = tb; cin8 = tc; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    checks++; if (ov8 !== 1'b0) begin
      errors++; $display("FAIL %s early_valid: got %b want 0", name, ov8); end
    @(posedge clk); #1;
    checks++; if (ov8 !== 1'b1 || {co8, s8} !== {ec, es}) begin
      errors++; $display("FAIL %s result: valid=%b cout=%b sum=%h want 1 %b %h", name, ov8, co8, s8, ec, es); end
`ifdef PIPELINED_ADDER_OVF_EN
    checks++; if (ovf8 !== eo) begin
      errors++; $display("FAIL %s ovf: got %b want %b", name, ovf8, eo); end
`else
    if (eo === 1'bx) $display("note: unknown overflow expectation for %s", name);
`endif
    @(posedge clk); #1;
    checks++; if (ov8 !== 1'b0) begin
      errors++; $display("FAIL %s one_cycle: valid got %b want 0", name, ov8); end
  endtask

  task automatic test_single_ops();
    run_op8("ff_plus_1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op8("cin_only",   8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run_op8("pos_ovf",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op8("neg_ovf",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] sa [16];
    logic [7:0] sb [16];
    logic       sc [16];
    logic [8:0] ref9;
    for (int i = 0; i < 16; i++) begin
      sa[i] = 8'(i * 53 + 17);
      sb[i] = 8'(i * 29 + 200);
      sc[i] = i[0];
    end
    for (int c = 0; c < 19; c++) begin
      if (c < 2 || c > 17) begin
        checks++; if (ov8 !== 1'b0) begin
          errors++; $display("FAIL stream_idle c=%0d: valid got %b want 0", c, ov8); end
      end else begin
        ref9 = {1'b0, sa[c-2]} + {1'b0, sb[c-2]} + {8'h00, sc[c-2]};
        checks++; if (ov8 !== 1'b1 || {co8, s8} !== ref9) begin
          errors++; $display("FAIL stream_res %0d: valid=%b got %h want %h", c - 2, ov8, {co8, s8}, ref9); end
      end
      if (c < 16) begin
        checks++; if (ir8 !== 1'b1) begin
          errors++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, ir8); end
        a8 = sa[c]; b8 = sb[c]; cin8 = sc[c]; iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    or8 = 1'b0;
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++; $display("FAIL bp_first: valid=%b in_ready=%b want 0 1", ov8, ir8); end
    a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h05; b8 = 8'h06; cin8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ov8 !== 1'b1 || {co8, s8} !== 9'h033 || ir8 !== 1'b0) begin
        errors++; $display("FAIL bp_hold %0d: valid=%b res=%h in_ready=%b want 1 033 0", i, ov8, {co8, s8}, ir8); end
      @(posedge clk); #1;
    end
    or8 = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", ir8); end
    @(posedge clk); #1;
    iv8 = 1'b0;
    checks++; if (ov8 !== 1'b1 || {co8, s8} !== 9'h111) begin
      errors++; $display("FAIL bp_drain2: valid=%b res=%h want 1 111", ov8, {co8, s8}); end
    @(posedge clk); #1;
    checks++; if (ov8 !== 1'b1 || {co8, s8} !== 9'h00B) begin
      errors++; $display("FAIL bp_drain3: valid=%b res=%h want 1 00b", ov8, {co8, s8}); end
    @(posedge clk); #1;
    checks++; if (ov8 !== 1'b0) begin
      errors++; $display("FAIL bp_no_dup: valid got %b want 0", ov8); end
  endtask

  task automatic test_reset_midflight();
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    checks++; if (ov8 !== 1'b1 || s8 !== 8'h46) begin
      errors++; $display("FAIL rst_pre: valid=%b sum=%h want 1 46", ov8, s8); end
    rst_n = 1'b0;
    #1;
    checks++; if (ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0) begin
      errors++; $display("FAIL rst_async: valid/sum/cout=%b/%h/%b want 0/00/0", ov8, s8, co8); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready: got %b want 1", ir8); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (ov8 !== 1'b0) begin
        errors++; $display("FAIL rst_stale %0d: valid got %b want 0", i, ov8); end
    end
  endtask

  task automatic run_op16(input string name, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic [15:0] es, input logic ec, input logic eo);
    a16 = ta; b16 = tb; cin16 = tc; iv16 = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      iv16 = 1'b0;
      checks++; if (ov16 !== 1'b0) begin
        errors++; $display("FAIL %s early_valid cyc %0d: got %b want 0", name, i, ov16); end
    end
    @(posedge clk); #1;
    checks++; if (ov16 !== 1'b1 || {co16, s16} !== {ec, es}) begin
      errors++; $display("FAIL %s result: valid=%b cout=%b sum=%h want 1 %b %h", name, ov16, co16, s16, ec, es); end
`ifdef PIPELINED_ADDER_OVF_EN
    checks++; if (ovf16 !== eo) begin
      errors++; $display("FAIL %s ovf: got %b want %b", name, ovf16, eo); end
`else
    if (eo === 1'bx) $display("note: unknown overflow expectation for %s", name);
`endif
    @(posedge clk); #1;
    checks++; if (ov16 !== 1'b0) begin
      errors++; $display("FAIL %s one_cycle: valid got %b want 0", name, ov16); end
  endtask

  task automatic test_wide();
    run_op16("w16_ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op16("w16_ripple",      16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0);
    run_op16("w16_neg_ovf",     16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic run_op1(input string name, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic [7:0] es, input logic ec, input logic eo);
    a1 = ta; b1 = tb; cin1 = tc; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    checks++; if (ov1 !== 1'b1 || {co1, s1} !== {ec, es}) begin
      errors++; $display("FAIL %s result: valid=%b cout=%b sum=%h want 1 %b %h", name, ov1, co1, s1, ec, es); end
`ifdef PIPELINED_ADDER_OVF_EN
    checks++; if (ovf1 !== eo) begin
      errors++; $display("FAIL %s ovf: got %b want %b", name, ovf1, eo); end
`else
    if (eo === 1'bx) $display("note: unknown overflow expectation for %s", name);
`endif
    @(posedge clk); #1;
    checks++; if (ov1 !== 1'b0) begin
      errors++; $display("FAIL %s one_cycle: valid got %b want 0", name, ov1); end
  endtask

  task automatic test_single_stage();
    run_op1("s1_aa_55_cin", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op1("s1_pos_ovf",   8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op1("s1_small",     8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    iv8 = 1'b0;  a8 = '0;  b8 = '0;  cin8 = 1'b0;  or8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; or16 = 1'b1;
    iv1 = 1'b0;  a1 = '0;  b1 = '0;  cin1 = 1'b0;  or1 = 1'b1;
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_wide();
    test_single_stage();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined N-bit ripple-carry adder with valid/ready handshaking, built from chained full-adder slices. Operands are split into `STAGES` equal chunks; each pipeline stage adds one chunk and registers its carry for the next stage, so the critical path covers `WIDTH/STAGES` bits instead of `WIDTH`. It is the arithmetic back end for multi-bit datapaths that previously used hand-chained full adders, and it accepts one operation per cycle under backpressure.

## Interface
- `WIDTH`, 8: operand and sum width in bits; must be a multiple of `STAGES`.
- `STAGES`, 2: number of pipeline stages, 1..`WIDTH`; chunk width `CHUNK = WIDTH/STAGES`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  adder can accept operands this cycle.
- `a`  in  WIDTH  operand A, unsigned or two's-complement.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  WIDTH  `(a + b + cin) mod 2^WIDTH`.
- `cout`  out  1  carry out of bit `WIDTH-1`.
- `ovf`  out  1  signed overflow; present only with `PIPELINED_ADDER_OVF_EN`.

## Operation
- Stage k (0..STAGES-1) adds chunk k (bits `k*CHUNK +: CHUNK`) of A and B plus the incoming carry: `cin` for k=0, the registered carry of stage k-1 otherwise.
- Each stage register holds: valid bit, completed sum chunks 0..k, the unprocessed upper chunks of A and B, the carry out of chunk k, and, with the macro, the carry into bit `WIDTH-1`.
- Stage 0 computes combinationally from the ports. Stage k computes from register k-1. The outputs are driven directly from register `STAGES-1`.
- Advance rule: register k loads when `!valid_k || ready_k`. Here `ready_{STAGES-1} = out_ready` and `ready_k = !valid_{k+1} || ready_{k+1}`. `in_ready = !valid_0 || ready_0`. Bubbles collapse.
- Input accept happens when `in_valid && in_ready`. A register with no new valid data loading into it, but whose content advances, clears its valid bit.
- While `out_valid && !out_ready`, `sum`, `cout` and `ovf` hold stable. Upstream stages fill; once all are full, `in_ready` drops.
- Arithmetic is pure modulo-2^WIDTH with no saturation. `cout` is the unsigned carry.
- Reset: all valid bits, data registers, `sum`, `cout` and `ovf` are 0. `in_ready` is 1 as soon as `rst_n` deasserts.
- Reset asserted mid-operation discards all in-flight results. No partial result is ever presented.

## Timing
- Latency is exactly `STAGES` cycles. An operation accepted at edge t shows `out_valid=1` after edge `t+STAGES-1` when no stall occurs.
- Throughput is one result per cycle with `out_ready` held high.
- `in_ready` depends combinationally on `out_ready` through the ready chain. There is no combinational path from `a`, `b` or `cin` to any output.
- Critical path is one `CHUNK`-bit ripple plus the register setup.

## Configuration
- `PIPELINED_ADDER_OVF_EN` defined: the `ovf` port exists. `ovf = c_in(MSB) ^ cout`, aligned with `sum`, and resets to 0.
- `PIPELINED_ADDER_OVF_EN` undefined: the port and its pipeline bits are absent. All other behaviour is identical.

## Structure
- Package `adder_pkg` holds the default `WIDTH` and `STAGES` values and the derived `CHUNK` function/constant. It also holds an elaboration check that `WIDTH % STAGES == 0`.
- Sub-module `adder_slice` (parameter `CHUNK`) is a combinational `CHUNK`-bit ripple of full-adder cells. It outputs the sum chunk, carry-out and carry-into-MSB. It is instantiated once per stage via generate.

## Test plan
- WIDTH=8, STAGES=2, single op: a=0xFF, b=0x01, cin=0 → after 2 cycles `sum`=0x00, `cout`=1, `out_valid` high for one cycle with `out_ready`=1.
- a=0x00, b=0x00, cin=1 → `sum`=0x01, `cout`=0. a=0x7F, b=0x01 → `sum`=0x80, `ovf`=1 (macro defined). a=0x80, b=0x80 → `sum`=0x00, `cout`=1, `ovf`=1.
- Stream 16 random ops back-to-back with `out_ready`=1 → 16 results in order, consecutive cycles, all matching a reference model including `cout`.
- Hold `out_ready`=0 while feeding ops → `in_ready` drops after 2 accepts, and `sum` stays stable. Release `out_ready` → both results drain in order with no loss or duplication.
- Assert `rst_n`=0 with 2 ops in flight → `out_valid`=0, `sum`=0, `cout`=0 immediately. After release, `in_ready`=1 and no stale result appears.
- WIDTH=16, STAGES=4 and WIDTH=8, STAGES=1: a=0xFFFF, b=0x0001 → `sum`=0x0000, `cout`=1 at latency 4. a=0xAA, b=0x55, cin=1 → `sum`=0x00, `cout`=1 at latency 1.
